// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one product/quotient bit per cycle, start/busy/done handshake.
// Optional build macro MDU_EARLY_OUT_EN finishes zero-operand requests in one cycle.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_funct3;
  logic [XLEN-1:0]   r_opnd;
  logic [2*XLEN-1:0] r_acc;
  logic              r_negp;
  logic              r_negr;
  logic [XLEN-1:0]   r_result;

  logic              w_sgnA;
  logic              w_sgnB;
  logic              w_negA;
  logic              w_negB;
  logic [XLEN-1:0]   w_magA;
  logic [XLEN-1:0]   w_magB;
  logic [XLEN:0]     w_mulSum;
  logic [2*XLEN-1:0] w_mulNext;
  logic [XLEN:0]     w_divShift;
  logic              w_divGe;
  logic [XLEN-1:0]   w_divSub;
  logic [2*XLEN-1:0] w_divNext;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fixResult;

  assign busy   = (r_state == S_CALC) || (r_state == S_FIX);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

  // MULH/MULHSU/DIV/REM treat rs1 as signed; only MULH/DIV/REM treat rs2 as signed.
  assign w_sgnA = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_sgnB = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_negA = w_sgnA & op_a[XLEN-1];
  assign w_negB = w_sgnB & op_b[XLEN-1];
  assign w_magA = w_negA ? -op_a : op_a;
  assign w_magB = w_negB ? -op_b : op_b;

  // r_acc holds {partial product, multiplier} for multiplies and {remainder, quotient} for divides.
  assign w_mulSum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mulNext = {w_mulSum, r_acc[XLEN-1:1]};

  assign w_divShift = r_acc[2*XLEN-1:XLEN-1];
  assign w_divGe    = (w_divShift >= {1'b0, r_opnd});
  assign w_divSub   = w_divShift[XLEN-1:0] - r_opnd;
  assign w_divNext  = w_divGe ? {w_divSub, r_acc[XLEN-2:0], 1'b1}
                              : {w_divShift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};

  // A zero divisor must yield all ones regardless of the dividend sign.
  assign w_prod = r_negp ? -r_acc : r_acc;
  assign w_quo  = (r_opnd == '0) ? '1 : (r_negp ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0]);
  assign w_rem  = r_negr ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fixResult = w_rem;
    case (r_funct3)
      3'b000:                 w_fixResult = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fixResult = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fixResult = w_quo;
      default:                w_fixResult = w_rem;
    endcase
  end

`ifdef MDU_EARLY_OUT_EN
  logic            w_early;
  logic [XLEN-1:0] w_earlyResult;

  assign w_early = (op_a == '0) || (op_b == '0);

  always_comb begin
    w_earlyResult = '0;
    if (funct3[2] && (op_b == '0)) begin
      w_earlyResult = funct3[1] ? op_a : '1;
    end
  end
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_negp   <= 1'b0;
      r_negr   <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_funct3 <= funct3;
            r_negp   <= w_negA ^ w_negB;
            r_negr   <= w_negA;
            r_cnt    <= '0;
            r_opnd   <= funct3[2] ? w_magB : w_magA;
            r_acc    <= {{XLEN{1'b0}}, (funct3[2] ? w_magA : w_magB)};
`ifdef MDU_EARLY_OUT_EN
            if (w_early) begin
              r_state  <= S_DONE;
              r_result <= w_earlyResult;
            end else begin
              r_state <= S_CALC;
            end
`else
            r_state <= S_CALC;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_acc <= r_funct3[2] ? w_divNext : w_mulNext;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(XLEN-1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_result <= w_fixResult;
          r_state  <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: table of operations plus reset and handshake sequences.
// Latency of zero-operand requests follows MDU_EARLY_OUT_EN when the bench is built with it.
module tb_mul_div_unit;

  localparam int LAT_FULL = 34;
`ifdef MDU_EARLY_OUT_EN
  localparam int LAT_ZERO = 1;
`else
  localparam int LAT_ZERO = 34;
`endif

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic        CLK;
  logic        RSTn;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int   checkCount = 0;
  int   passCount  = 0;
  vec_t vecs[$];

  mul_div_unit #(.XLEN(32)) dut (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issues one request and waits (bounded) for done; lat counts edges from the sampling edge.
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               output int lat, output int busyErr);
    @(negedge CLK);
    funct3 = f;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    @(posedge CLK);
    #1;
    start   = 1'b0;
    lat     = 1;
    busyErr = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busyErr++;
      @(posedge CLK);
      #1;
      lat++;
    end
    if (busy !== 1'b0) busyErr++;
  endtask

  initial begin
    int lat;
    int busyErr;
    int expLat;
    int pulses;

    vecs.push_back('{3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE});
    vecs.push_back('{3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF});
    vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001});
    vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF});
    vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD});
    vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF});
    vecs.push_back('{3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC});
    vecs.push_back('{3'b111, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001});
    vecs.push_back('{3'b100, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF});
    vecs.push_back('{3'b111, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234});
    vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD});
    vecs.push_back('{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
    vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    vecs.push_back('{3'b100, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFFF});
    vecs.push_back('{3'b110, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8});
    vecs.push_back('{3'b101, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000});
    vecs.push_back('{3'b010, 32'hFFFF_FFFE, 32'h8000_0000, 32'hFFFF_FFFF});
    vecs.push_back('{3'b000, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A});

    RSTn   = 1'b0;
    start  = 1'b0;
    funct3 = 3'b000;
    op_a   = '0;
    op_b   = '0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset done", {31'b0, done}, 32'd0);
    checkOutput("reset result", result, 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].f, vecs[i].a, vecs[i].b, lat, busyErr);
      expLat = (vecs[i].a == 32'd0 || vecs[i].b == 32'd0) ? LAT_ZERO : LAT_FULL;
      checkOutput($sformatf("vec%0d result", i), result, vecs[i].exp);
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(expLat));
      checkOutput($sformatf("vec%0d busy profile errors", i), 32'(busyErr), 32'd0);
      @(posedge CLK);
      #1;
      checkOutput($sformatf("vec%0d done single pulse", i), {31'b0, done}, 32'd0);
      checkOutput($sformatf("vec%0d result held", i), result, vecs[i].exp);
    end

    // start held high with changing operands during CALC must not disturb the latched request
    @(negedge CLK);
    funct3 = 3'b000;
    op_a   = 32'd7;
    op_b   = 32'd6;
    start  = 1'b1;
    @(posedge CLK);
    #1;
    lat     = 1;
    busyErr = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (lat < 20) begin
        op_a   = $urandom;
        op_b   = $urandom;
        funct3 = 3'(lat);
      end else begin
        start = 1'b0;
      end
      if (busy !== 1'b1) busyErr++;
      @(posedge CLK);
      #1;
      lat++;
    end
    start = 1'b0;
    checkOutput("held start result", result, 32'd42);
    checkOutput("held start latency", 32'(lat), 32'(LAT_FULL));
    checkOutput("held start busy profile errors", 32'(busyErr), 32'd0);

    // back-to-back: new request accepted in the DONE cycle of the previous one
    applyStimulus(3'b000, 32'd7, 32'd6, lat, busyErr);
    checkOutput("b2b first result", result, 32'd42);
    checkOutput("b2b first latency", 32'(lat), 32'(LAT_FULL));
    funct3 = 3'b101;
    op_a   = 32'd100;
    op_b   = 32'd7;
    start  = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    checkOutput("b2b accept done low", {31'b0, done}, 32'd0);
    checkOutput("b2b accept busy high", {31'b0, busy}, 32'd1);
    checkOutput("b2b result stable in CALC", result, 32'd42);
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    checkOutput("b2b second result", result, 32'd14);
    checkOutput("b2b second latency", 32'(lat), 32'(LAT_FULL));
    @(posedge CLK);
    #1;
    checkOutput("b2b second done single pulse", {31'b0, done}, 32'd0);

    // asynchronous reset during CALC discards the operation
    @(negedge CLK);
    funct3 = 3'b000;
    op_a   = 32'd7;
    op_b   = 32'd6;
    start  = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (9) @(posedge CLK);
    #2;
    RSTn = 1'b0;
    #1;
    checkOutput("mid reset busy", {31'b0, busy}, 32'd0);
    checkOutput("mid reset done", {31'b0, done}, 32'd0);
    checkOutput("mid reset result", result, 32'd0);
    @(negedge CLK);
    RSTn   = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge CLK);
      #1;
      if (done === 1'b1) pulses++;
    end
    checkOutput("no done after reset", 32'(pulses), 32'd0);
    checkOutput("idle after reset busy", {31'b0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
